// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2
  } tx_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;
  localparam logic STOP_ONE = 1'b0;
  localparam logic STOP_TWO = 1'b1;

  // Even parity is the XOR of the data bits; odd parity is its inverse.
  function automatic logic par_bit(input logic data_xor, input logic par_mode);
    return data_xor ^ (par_mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Single-clock FIFO for the transmit word buffer.
// Latency: a word pushed at edge N is visible at rd_data after edge N.
// Backpressure: push ignored when full, pop ignored when empty; full/empty/level are registered-state only.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign rd_data = mem[rd_ptr];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Storage array: written on accepted push, no reset needed.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers and occupancy; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      if (push_ok && !pop_ok)      count <= count + (AW+1)'(1);
      else if (pop_ok && !push_ok) count <= count - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/uart_tx_buf.sv
// Buffered UART transmitter: FIFO of words, serialised start/data/parity/stop at a programmable baud divisor.
// Latency: word pushed at edge N into an empty idle block drives the start bit from edge N+1.
// Backpressure: in_ready = !full from registered state; a pop from a full buffer does not reopen in_ready that cycle.
module uart_tx_buf
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DIV_W-1:0]            cfg_div,
  input  logic                        cfg_par_en,
  input  logic                        cfg_par_odd,
  input  logic                        cfg_stop2,
  input  logic [DATA_W-1:0]           in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic                        tx_out,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        tx_done
);

  localparam int IDX_W = $clog2(DATA_W);

  tx_state_t          state;
  logic [DIV_W-1:0]   div_q;
  logic [DIV_W-1:0]   cnt;
  logic [IDX_W-1:0]   bit_idx;
  logic [DATA_W-1:0]  shreg;
  logic               par_en_q;
  logic               par_q;
  logic               stop2_q;

  logic [DATA_W-1:0]  fifo_dout;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_pop;
  logic               bit_end;
  logic               last_stop;

  uart_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (in_valid && in_ready),
    .wr_data (in_data),
    .pop     (fifo_pop),
    .rd_data (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign in_ready = !fifo_full;
  assign busy     = (state != IDLE);

  // Bit timing and pop decision: load a new word from idle, or straight after the last stop bit.
  always_comb begin
    bit_end   = (cnt == div_q - DIV_W'(1));
    last_stop = (state == STOP2) || ((state == STOP1) && (stop2_q != STOP_TWO));
    fifo_pop  = !fifo_empty && ((state == IDLE) || (bit_end && last_stop));
  end

  // Frame sequencer: latches the frame config at load, steps one bit per divisor period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      div_q    <= DIV_W'(1);
      cnt      <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
      stop2_q  <= STOP_ONE;
      tx_out   <= 1'b1;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (fifo_pop) begin
        state    <= START;
        div_q    <= (cfg_div == '0) ? DIV_W'(1) : cfg_div;
        par_en_q <= cfg_par_en;
        par_q    <= par_bit(^fifo_dout, cfg_par_odd);
        stop2_q  <= cfg_stop2;
        shreg    <= fifo_dout;
        cnt      <= '0;
        bit_idx  <= '0;
        tx_out   <= 1'b0;
        if (state != IDLE) tx_done <= 1'b1;
      end else if (state != IDLE) begin
        if (!bit_end) begin
          cnt <= cnt + DIV_W'(1);
        end else begin
          cnt <= '0;
          case (state)
            START: begin
              state  <= DATA;
              tx_out <= shreg[0];
            end
            DATA: begin
              if (bit_idx == IDX_W'(DATA_W - 1)) begin
                if (par_en_q) begin
                  state  <= PARITY;
                  tx_out <= par_q;
                end else begin
                  state  <= STOP1;
                  tx_out <= 1'b1;
                end
              end else begin
                bit_idx <= bit_idx + IDX_W'(1);
                shreg   <= shreg >> 1;
                tx_out  <= shreg[1];
              end
            end
            PARITY: begin
              state  <= STOP1;
              tx_out <= 1'b1;
            end
            STOP1: begin
              if (stop2_q == STOP_TWO) begin
                state <= STOP2;
              end else begin
                state   <= IDLE;
                tx_done <= 1'b1;
              end
              tx_out <= 1'b1;
            end
            default: begin
              state   <= IDLE;
              tx_done <= (state == STOP2);
              tx_out  <= 1'b1;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_buf.sv
// Self-checking bench for uart_tx_buf: directed steps, per-frame scoreboard checked bit by bit on the serial line.
module tb_uart_tx_buf;

  logic        clk;
  logic        rst;
  logic [15:0] cfg_div;
  logic        cfg_par_en;
  logic        cfg_par_odd;
  logic        cfg_stop2;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        tx_out;
  logic        busy;
  logic [3:0]  fifo_level;
  logic        tx_done;

  uart_tx_buf #(
    .DATA_W     (8),
    .FIFO_DEPTH (8),
    .DIV_W      (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_div     (cfg_div),
    .cfg_par_en  (cfg_par_en),
    .cfg_par_odd (cfg_par_odd),
    .cfg_stop2   (cfg_stop2),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .tx_out      (tx_out),
    .busy        (busy),
    .fifo_level  (fifo_level),
    .tx_done     (tx_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         div;
    logic       par_en;
    logic       odd;
    logic       stop2;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int          done_cnt = 0;
  bit          contig = 0;
  bit          mon_on = 0;
  int          mon_cyc = 0;
  int          mon_len = 0;
  int          mon_div = 1;
  logic [15:0] mon_bits;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Pop the next expected frame and expand it into its serial bit sequence.
  task automatic start_frame();
    exp_t e;
    int   nb;
    chk("frame_expected", 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      nb = 0;
      mon_bits = '0;
      mon_bits[nb] = 1'b0; nb++;
      for (int i = 0; i < 8; i++) begin
        mon_bits[nb] = e.data[i]; nb++;
      end
      if (e.par_en) begin
        mon_bits[nb] = (^e.data) ^ e.odd; nb++;
      end
      mon_bits[nb] = 1'b1; nb++;
      if (e.stop2) begin
        mon_bits[nb] = 1'b1; nb++;
      end
      mon_div = e.div;
      mon_len = nb * e.div;
      mon_cyc = 1;
      mon_on  = 1;
    end
  endtask

  // Line monitor: checks every cycle of each frame and the tx_done pulse right after it.
  always @(negedge clk) begin
    if (rst) begin
      mon_on = 0;
    end else if (mon_on && mon_cyc == mon_len) begin
      chk("tx_done_pulse", 32'(tx_done), 32'd1);
      done_cnt++;
      mon_on = 0;
      if (contig && sb.size() != 0) chk("no_gap", 32'(tx_out), 32'd0);
      if (tx_out == 1'b0) start_frame();
    end else if (mon_on) begin
      chk($sformatf("line_bit_c%0d", mon_cyc), 32'(tx_out), 32'(mon_bits[mon_cyc / mon_div]));
      chk("tx_done_low", 32'(tx_done), 32'd0);
      mon_cyc++;
    end else if (tx_out == 1'b0) begin
      start_frame();
    end
  end

  task automatic push(input logic [7:0] d, input int dv);
    bit   rdy;
    bit   acc;
    exp_t e;
    acc = 0;
    in_data  = d;
    in_valid = 1'b1;
    for (int i = 0; i < 500; i++) begin
      rdy = in_ready;
      @(posedge clk); #1;
      if (rdy) begin
        acc = 1;
        break;
      end
    end
    in_valid = 1'b0;
    chk("push_accept", 32'(acc), 32'd1);
    if (acc) begin
      e.data = d; e.div = dv; e.par_en = cfg_par_en; e.odd = cfg_par_odd; e.stop2 = cfg_stop2;
      sb.push_back(e);
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #2;
      if (!mon_on && sb.size() == 0 && !busy) begin
        ok = 1;
        break;
      end
    end
    chk("drain", 32'(ok), 32'd1);
  endtask

  initial begin
    int d0;
    int lows;
    clk = 0; rst = 1;
    cfg_div = 16'd4; cfg_par_en = 1; cfg_par_odd = 0; cfg_stop2 = 0;
    in_data = '0; in_valid = 0;
    repeat (2) @(posedge clk); #1;
    chk("rst_tx_out", 32'(tx_out), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tx_done", 32'(tx_done), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 0;
    @(posedge clk); #1;

    // 0xA5, div 4, even parity, one stop: 44-cycle frame, start bit the edge after push.
    d0 = done_cnt;
    push(8'hA5, 4);
    @(posedge clk); #1;
    chk("latency_start", 32'(tx_out), 32'd0);
    chk("latency_busy", 32'(busy), 32'd1);
    chk("latency_level", 32'(fifo_level), 32'd0);
    wait_idle();
    chk("a5_done_count", 32'(done_cnt - d0), 32'd1);

    // 0x00, div 2, odd parity, two stops: parity 1, 26-cycle frame.
    cfg_div = 16'd2; cfg_par_odd = 1; cfg_stop2 = 1;
    push(8'h00, 2);
    wait_idle();

    // Nine back-to-back words into an 8-deep buffer.
    cfg_div = 16'd2; cfg_par_en = 0; cfg_par_odd = 0; cfg_stop2 = 0;
    d0 = done_cnt;
    for (int i = 0; i < 9; i++) push(8'h31 + 8'(i * 7), 2);
    chk("full_level", 32'(fifo_level), 32'd8);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    contig = 1;
    in_data = 8'h77; in_valid = 1;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 0;
    chk("full_ignore_level", 32'(fifo_level), 32'd8);
    wait_idle();
    contig = 0;
    chk("burst_done_count", 32'(done_cnt - d0), 32'd9);

    // Divisor change mid-frame applies only to the next frame.
    cfg_div = 16'd4;
    push(8'h5A, 4);
    push(8'hC3, 8);
    cfg_div = 16'd8;
    wait_idle();

    // Divisor 0 behaves as 1 cycle per bit.
    cfg_div = 16'd0;
    push(8'h3C, 1);
    wait_idle();

    // Reset during data bit 3 with three words still buffered.
    cfg_div = 16'd4;
    for (int i = 0; i < 4; i++) push(8'hF0, 4);
    repeat (15) @(posedge clk);
    #1;
    chk("pre_rst_bit3", 32'(tx_out), 32'd0);
    chk("pre_rst_level", 32'(fifo_level), 32'd3);
    rst = 1;
    sb.delete();
    #1;
    chk("mid_rst_tx_out", 32'(tx_out), 32'd1);
    chk("mid_rst_level", 32'(fifo_level), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx_out !== 1'b1) lows++;
    end
    chk("post_rst_line_idle", 32'(lows), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_level", 32'(fifo_level), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_buf.md
UART_TX_BUF -- requirements
Module: uart_tx_buf

Interface
REQ-001 SHALL have parameter DATA_W, default 8, frame data bits (legal 5..9).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, input buffer entries (power of 2, >=2).
REQ-003 SHALL have parameter DIV_W, default 16, baud divisor width.
REQ-004 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port cfg_div  in  DIV_W  clk cycles per bit; 0 treated as 1.
REQ-007 SHALL have port cfg_par_en  in  1  parity bit enable.
REQ-008 SHALL have port cfg_par_odd  in  1  1 = odd parity, 0 = even.
REQ-009 SHALL have port cfg_stop2  in  1  1 = two stop bits, 0 = one.
REQ-010 SHALL have port in_data  in  DATA_W  word to transmit.
REQ-011 SHALL have port in_valid  in  1  in_data valid.
REQ-012 SHALL have port in_ready  out  1  buffer can accept; equals !full, from registered state only.
REQ-013 SHALL have port tx_out  out  1  serial line, idle high, registered.
REQ-014 SHALL have port busy  out  1  frame in progress (FSM not IDLE).
REQ-015 SHALL have port fifo_level  out  $clog2(FIFO_DEPTH)+1  occupied entries.
REQ-016 SHALL have port tx_done  out  1  one-cycle pulse at end of each frame's last stop bit.

Function
REQ-017 Push SHALL occur on any edge with in_valid && in_ready; in_valid while !in_ready SHALL be ignored, no data lost from buffer.
REQ-018 fifo_level SHALL change +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-019 FSM states SHALL be IDLE, START, DATA, PARITY, STOP1, STOP2.
REQ-020 IDLE with buffer non-empty SHALL pop the head, latch cfg_div, cfg_par_en, cfg_par_odd, cfg_stop2, load shift register, clear baud counter, and enter START.
REQ-021 Cfg changes during a frame SHALL NOT affect that frame.
REQ-022 Each bit SHALL last exactly max(cfg_div,1) clk cycles; baud counter counts 0..div-1, advancing the FSM on the terminal count.
REQ-023 Bit order SHALL be: start (0), DATA_W data bits LSB first, parity if enabled, STOP1 (1), STOP2 (1) if cfg_stop2.
REQ-024 Parity SHALL be XOR of the data bits for even, its inverse for odd.
REQ-025 Latency: word pushed at edge N into empty, idle block SHALL produce tx_out=0 from edge N+1.
REQ-026 At terminal count of last stop bit with buffer non-empty, FSM SHALL go directly to START (no idle cycle); otherwise IDLE.
REQ-027 tx_done SHALL be high for the single cycle following the last stop bit's terminal count edge.
REQ-028 Frame duration SHALL be div*(1+DATA_W+par_en+1+stop2) cycles.
REQ-029 Full buffer with pop in same cycle SHALL keep in_ready low that cycle (no same-cycle refill).

Reset
REQ-030 rst high SHALL immediately force tx_out=1, busy=0, tx_done=0, fifo_level=0, in_ready=1, FSM=IDLE, counters 0.
REQ-031 Reset mid-frame SHALL abort the frame and discard all buffered words; no partial frame resumes after release.

Structure
REQ-032 Package uart_pkg SHALL hold the FSM state enum and parity/stop-mode constants.
REQ-033 Buffer SHALL be a separate sub-module uart_fifo (synchronous, single clock, parameterised width/depth).

Verification
REQ-034 DATA_W=8, div=4, par even, 1 stop, push 0xA5 -> tx_out 0,1,0,1,0,0,1,0,1,0,1 at 4 cycles each (44 cycles), tx_done once.
REQ-035 Push 0x00, div=2, odd parity, stop2 -> parity bit 1, 26-cycle frame, two high stop bits.
REQ-036 Push 9 words back-to-back, FIFO_DEPTH=8 -> in_ready low after 8th accepted beyond first pop, all 9 frames sent contiguous with no idle gap.
REQ-037 Change cfg_div 4->8 mid-frame -> current frame stays 4 cycles/bit, next frame 8.
REQ-038 Assert rst during DATA bit 3 with 3 words buffered -> tx_out=1 same cycle, fifo_level=0, no further frames after release.
REQ-039 cfg_div=0 -> each bit lasts 1 cycle.
